// File: rtl/matrix_mult_vector_arbiter.sv
// Round-robin scheduler sharing one matrix_mult_vector multiplier between NUM_REQ requesters.
// Latches the winner's operands, pulses the multiplier reset, holds calc until ready or timeout.
module matrix_mult_vector_arbiter #(
  parameter int unsigned NUM_REQ        = 2,
  parameter int unsigned MATRIX_WIDTH   = 2,
  parameter int unsigned MATRIX_HEIGHT  = 2,
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned MATRIX_WEIGHT  = MATRIX_WIDTH * MATRIX_HEIGHT,
  parameter int unsigned MATRIX_SIZE    = MATRIX_WEIGHT * DATA_WIDTH,
  parameter int unsigned VECTOR_SIZE    = MATRIX_WIDTH * DATA_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                           clk,
  input  logic                           i_rst,
  input  logic [NUM_REQ-1:0]             i_req,
  input  logic [NUM_REQ*MATRIX_SIZE-1:0] i_matrix,
  input  logic [NUM_REQ*VECTOR_SIZE-1:0] i_vector,
  output logic [NUM_REQ-1:0]             o_grant,
  output logic [NUM_REQ-1:0]             o_done,
  output logic                           o_timeout,
  output logic [MATRIX_SIZE-1:0]         o_result,
  output logic                           o_mul_calc,
  output logic                           o_mul_rst_n,
  output logic [MATRIX_SIZE-1:0]         o_mul_matrix,
  output logic [VECTOR_SIZE-1:0]         o_mul_vector,
  input  logic [MATRIX_SIZE-1:0]         i_mul_result,
  input  logic                           i_mul_ready
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  localparam logic [PTR_W:0]   NREQ_X   = (PTR_W+1)'(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_REQ = PTR_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CLEAR = 2'd1;
  localparam logic [1:0] CALC  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  logic [1:0]             state_q,      state_d;
  logic [PTR_W-1:0]       rr_ptr_q,     rr_ptr_d;
  logic [PTR_W-1:0]       winner_q,     winner_d;
  logic [CNT_W-1:0]       cnt_q,        cnt_d;
  logic [NUM_REQ-1:0]     grant_q,      grant_d;
  logic [NUM_REQ-1:0]     done_q,       done_d;
  logic                   timeout_q,    timeout_d;
  logic [MATRIX_SIZE-1:0] result_q,     result_d;
  logic                   mul_calc_q,   mul_calc_d;
  logic                   mul_rst_n_q,  mul_rst_n_d;
  logic [MATRIX_SIZE-1:0] mul_matrix_q, mul_matrix_d;
  logic [VECTOR_SIZE-1:0] mul_vector_q, mul_vector_d;

  logic                   arb_found;
  logic [PTR_W-1:0]       arb_win;
  logic [PTR_W:0]         arb_cand;
  logic [MATRIX_SIZE-1:0] sel_matrix;
  logic [VECTOR_SIZE-1:0] sel_vector;

  // First requesting index at or above rr_ptr, wrapping modulo NUM_REQ.
  always_comb begin
    arb_found = 1'b0;
    arb_win   = '0;
    arb_cand  = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      arb_cand = {1'b0, rr_ptr_q} + (PTR_W+1)'(i);
      if (arb_cand >= NREQ_X) begin
        arb_cand = arb_cand - NREQ_X;
      end
      if (!arb_found && i_req[arb_cand[PTR_W-1:0]]) begin
        arb_found = 1'b1;
        arb_win   = arb_cand[PTR_W-1:0];
      end
    end
  end

  always_comb begin
    sel_matrix = '0;
    sel_vector = '0;
    for (int unsigned r = 0; r < NUM_REQ; r++) begin
      if (arb_win == PTR_W'(r)) begin
        sel_matrix = i_matrix[r*MATRIX_SIZE +: MATRIX_SIZE];
        sel_vector = i_vector[r*VECTOR_SIZE +: VECTOR_SIZE];
      end
    end
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    winner_d     = winner_q;
    cnt_d        = cnt_q;
    grant_d      = grant_q;
    done_d       = '0;
    timeout_d    = 1'b0;
    result_d     = result_q;
    mul_calc_d   = 1'b0;
    mul_rst_n_d  = 1'b1;
    mul_matrix_d = mul_matrix_q;
    mul_vector_d = mul_vector_q;

    case (state_q)
      IDLE: begin
        grant_d = '0;
        if (arb_found) begin
          state_d      = CLEAR;
          winner_d     = arb_win;
          grant_d      = NUM_REQ'(1) << arb_win;
          mul_matrix_d = sel_matrix;
          mul_vector_d = sel_vector;
          mul_rst_n_d  = 1'b0;
        end
      end
      CLEAR: begin
        state_d    = CALC;
        cnt_d      = '0;
        mul_calc_d = 1'b1;
      end
      CALC: begin
        cnt_d = cnt_q + CNT_W'(1);
        // Ready takes priority over an expiring counter in the same cycle.
        if (i_mul_ready) begin
          state_d  = DONE;
          result_d = i_mul_result;
          done_d   = grant_q;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = DONE;
          timeout_d = 1'b1;
          done_d    = grant_q;
        end else begin
          mul_calc_d = 1'b1;
        end
      end
      DONE: begin
        state_d  = IDLE;
        grant_d  = '0;
        rr_ptr_d = (winner_q == LAST_REQ) ? '0 : winner_q + PTR_W'(1);
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
      end
    endcase
  end

  // Reset holds the multiplier in reset and aborts any job silently.
  always_ff @(posedge clk or posedge i_rst) begin
    if (i_rst) begin
      state_q      <= IDLE;
      rr_ptr_q     <= '0;
      winner_q     <= '0;
      cnt_q        <= '0;
      grant_q      <= '0;
      done_q       <= '0;
      timeout_q    <= 1'b0;
      result_q     <= '0;
      mul_calc_q   <= 1'b0;
      mul_rst_n_q  <= 1'b0;
      mul_matrix_q <= '0;
      mul_vector_q <= '0;
    end else begin
      state_q      <= state_d;
      rr_ptr_q     <= rr_ptr_d;
      winner_q     <= winner_d;
      cnt_q        <= cnt_d;
      grant_q      <= grant_d;
      done_q       <= done_d;
      timeout_q    <= timeout_d;
      result_q     <= result_d;
      mul_calc_q   <= mul_calc_d;
      mul_rst_n_q  <= mul_rst_n_d;
      mul_matrix_q <= mul_matrix_d;
      mul_vector_q <= mul_vector_d;
    end
  end

  assign o_grant      = grant_q;
  assign o_done       = done_q;
  assign o_timeout    = timeout_q;
  assign o_result     = result_q;
  assign o_mul_calc   = mul_calc_q;
  assign o_mul_rst_n  = mul_rst_n_q;
  assign o_mul_matrix = mul_matrix_q;
  assign o_mul_vector = mul_vector_q;

endmodule

// File: tb/tb_matrix_mult_vector_arbiter.sv
// Bench for matrix_mult_vector_arbiter: multiplier stub with programmable latency plus a
// job-level reference model (round-robin pointer, expected latency, expected result).
module tb_matrix_mult_vector_arbiter;

  localparam int NUM_REQ = 2;
  localparam int MS      = 32;
  localparam int VS      = 16;
  localparam int T       = 4;

  logic                   clk = 1'b0;
  logic                   i_rst = 1'b1;
  logic [NUM_REQ-1:0]     i_req = '0;
  logic [NUM_REQ*MS-1:0]  i_matrix = '0;
  logic [NUM_REQ*VS-1:0]  i_vector = '0;
  logic [NUM_REQ-1:0]     o_grant;
  logic [NUM_REQ-1:0]     o_done;
  logic                   o_timeout;
  logic [MS-1:0]          o_result;
  logic                   o_mul_calc;
  logic                   o_mul_rst_n;
  logic [MS-1:0]          o_mul_matrix;
  logic [VS-1:0]          o_mul_vector;
  logic [MS-1:0]          i_mul_result = '0;
  logic                   i_mul_ready = 1'b0;

  int            n_cmp = 0;
  int            n_bad = 0;
  int            model_ptr = 0;
  logic [MS-1:0] exp_result = '0;
  int            stub_lat = 0;
  int            stub_cnt = 0;
  logic [MS-1:0] stub_result = '0;

  matrix_mult_vector_arbiter #(
    .NUM_REQ(NUM_REQ), .MATRIX_WIDTH(2), .MATRIX_HEIGHT(2), .DATA_WIDTH(8),
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .i_rst(i_rst), .i_req(i_req), .i_matrix(i_matrix), .i_vector(i_vector),
    .o_grant(o_grant), .o_done(o_done), .o_timeout(o_timeout), .o_result(o_result),
    .o_mul_calc(o_mul_calc), .o_mul_rst_n(o_mul_rst_n), .o_mul_matrix(o_mul_matrix),
    .o_mul_vector(o_mul_vector), .i_mul_result(i_mul_result), .i_mul_ready(i_mul_ready)
  );

  always #5 clk = ~clk;

  // Multiplier stub: ready (held) from the stub_lat-th calc cycle; stub_lat 0 means never.
  always @(negedge clk) begin
    if (!o_mul_rst_n) stub_cnt = 0;
    else if (o_mul_calc) stub_cnt = stub_cnt + 1;
    i_mul_ready  = o_mul_calc && (stub_lat > 0) && (stub_cnt >= stub_lat);
    i_mul_result = i_mul_ready ? stub_result : $urandom;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_grant"},   64'(o_grant), 64'(0));
    chk({tag, "_done"},    64'(o_done), 64'(0));
    chk({tag, "_timeout"}, 64'(o_timeout), 64'(0));
    chk({tag, "_result"},  64'(o_result), 64'(0));
    chk({tag, "_calc"},    64'(o_mul_calc), 64'(0));
    chk({tag, "_rst_n"},   64'(o_mul_rst_n), 64'(0));
    chk({tag, "_matrix"},  64'(o_mul_matrix), 64'(0));
    chk({tag, "_vector"},  64'(o_mul_vector), 64'(0));
  endtask

  // One complete job, entered from an IDLE cycle; checks grant, operands, clear pulse,
  // calc duration, done/timeout pulse and result against the job-level model.
  task automatic run_job(input logic [1:0] req, input logic [63:0] mats, input logic [31:0] vecs,
                         input int lat, input logic [31:0] res, input bit drop);
    int  w, k, rst_lo, calc_hi, exp_k, rq, idx;
    bit  got_done, to_exp;
    logic [NUM_REQ-1:0] exp_g;
    w  = -1;
    rq = int'(req);
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = (model_ptr + i) % NUM_REQ;
      if (w < 0 && ((rq >> idx) & 1) != 0) w = idx;
    end
    exp_g = NUM_REQ'(1 << w);
    i_req = req; i_matrix = mats; i_vector = vecs;
    stub_lat = lat; stub_result = res;

    @(posedge clk); #1;
    chk("grant", 64'(o_grant), 64'(exp_g));
    chk("mul_matrix", 64'(o_mul_matrix), 64'(32'(mats >> (w * MS))));
    chk("mul_vector", 64'(o_mul_vector), 64'(16'(vecs >> (w * VS))));
    i_matrix = {$urandom, $urandom};
    i_vector = $urandom;
    if (drop) i_req = '0;

    rst_lo = (o_mul_rst_n == 1'b0) ? 1 : 0;
    calc_hi = 0; k = 0; got_done = 0;
    while (!got_done && k < T + 8) begin
      @(posedge clk); #1;
      k++;
      if (!o_mul_rst_n) rst_lo++;
      if (o_mul_calc) calc_hi++;
      if (o_done != '0) got_done = 1;
    end

    to_exp = !(lat >= 1 && lat <= T);
    exp_k  = to_exp ? T + 1 : lat + 1;
    if (!to_exp) exp_result = res;
    chk("done_latency", 64'(k), 64'(exp_k));
    chk("done", 64'(o_done), 64'(exp_g));
    chk("timeout", 64'(o_timeout), 64'(to_exp));
    chk("result", 64'(o_result), 64'(exp_result));
    chk("grant_in_done", 64'(o_grant), 64'(exp_g));
    chk("calc_low_in_done", 64'(o_mul_calc), 64'(0));
    chk("calc_cycles", 64'(calc_hi), 64'(exp_k - 1));
    chk("clear_cycles", 64'(rst_lo), 64'(1));
    model_ptr = (w + 1) % NUM_REQ;

    @(posedge clk); #1;
    chk("done_one_cycle", 64'(o_done), 64'(0));
    chk("timeout_one_cycle", 64'(o_timeout), 64'(0));
    chk("grant_idle", 64'(o_grant), 64'(0));
    chk("rst_n_idle", 64'(o_mul_rst_n), 64'(1));
  endtask

  initial begin
    logic [1:0] r;
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    i_rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_n_after_release", 64'(o_mul_rst_n), 64'(1));
    chk("grant_after_release", 64'(o_grant), 64'(0));

    // Single job from requester 1
    run_job(2'b10, {32'h0203060E, 32'h11223344}, {16'h0A0E, 16'h5566}, 3, 32'hDEADBEEF, 1'b0);

    // Round-robin with both requesting
    for (int j = 0; j < 4; j++)
      run_job(2'b11, {$urandom, $urandom}, $urandom, int'($urandom_range(1, 3)), $urandom, 1'b0);

    // Timeout (never ready), collision on the last allowed cycle, ready too late
    run_job(2'b01, {$urandom, $urandom}, $urandom, 0, $urandom, 1'b0);
    run_job(2'b10, {$urandom, $urandom}, $urandom, T, 32'hC0FFEE01, 1'b0);
    run_job(2'b11, {$urandom, $urandom}, $urandom, T + 1, $urandom, 1'b0);

    // Randomized jobs, some dropping the request after grant
    for (int j = 0; j < 12; j++) begin
      r = 2'($urandom_range(1, 3));
      run_job(r, {$urandom, $urandom}, $urandom, int'($urandom_range(0, 5)), $urandom,
              1'($urandom_range(0, 1)));
    end

    // Reset mid-CALC: park pointer at 1, start a job for requester 1, abort it
    run_job(2'b01, {$urandom, $urandom}, $urandom, 1, $urandom, 1'b0);
    i_req = 2'b11; stub_lat = 0;
    @(posedge clk); #1;
    chk("abort_grant", 64'(o_grant), 64'(2'b10));
    @(posedge clk); #1;
    chk("abort_calc1", 64'(o_mul_calc), 64'(1));
    @(posedge clk); #1;
    i_rst = 1'b1;
    #1;
    check_all_zero("midreset");
    for (int j = 0; j < 2; j++) begin
      @(posedge clk); #1;
      chk("abort_no_done", 64'(o_done), 64'(0));
    end
    i_rst = 1'b0;
    model_ptr  = 0;
    exp_result = '0;
    run_job(2'b11, {$urandom, $urandom}, $urandom, 2, $urandom, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
